// File: rtl/gnn_0_example_load.sv
// gnn_0_example_load: DRAM-to-buffer load engine; one AXI read request per instruction,
// beats pass through a skid FIFO and a registered write stage into consecutive buffer lines.
module gnn_0_example_load #(
    parameter int LOAD_INST_LENGTH   = 96,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BUF_ADDR_WIDTH   = 11,
    parameter int C_FIFO_DEPTH       = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          ap_start,
    output logic                          ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [LOAD_INST_LENGTH-1:0]   ctrl_instruction,
    output logic                          read_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] read_xfer_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]  read_xfer_size_in_bytes,
    input  logic                          data_tvalid,
    output logic                          data_tready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata,
    output logic                          load_write_buffer_valid,
    input  logic                          load_write_buffer_ready,
    output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_addr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_data
);
    localparam int PW = $clog2(C_FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, STREAM, DRAIN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [15:0]                     count_q, count_d, beats_q, beats_d, writes_q, writes_d;
    logic [C_BUF_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   xaddr_q, xaddr_d;
    logic [C_XFER_SIZE_WIDTH-1:0]    xsize_q, xsize_d;
    logic                            done_q, done_d;
    logic [PW-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]                     fcnt_q, fcnt_d;
    logic                            out_valid_q, out_valid_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   mem_q [C_FIFO_DEPTH];
    logic                            tready, push, pop, load, commit;
    logic                            unused_inst;

    assign unused_inst = ^{ctrl_instruction[31:0], ctrl_instruction[47:32+C_BUF_ADDR_WIDTH]};

    always_comb begin
        tready      = state_q == STREAM && fcnt_q < (PW+1)'(C_FIFO_DEPTH) && beats_q < count_q;
        push        = data_tvalid && tready;
        commit      = out_valid_q && load_write_buffer_ready;
        load        = !out_valid_q || load_write_buffer_ready;
        pop         = fcnt_q != '0 && load;
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        fcnt_d      = fcnt_q + (PW+1)'(push) - (PW+1)'(pop);
        // output stage refills whenever it is empty or being consumed this cycle
        out_valid_d = load ? fcnt_q != '0 : out_valid_q;
        out_data_d  = pop ? mem_q[rd_ptr_q] : out_data_q;
        beats_d     = beats_q + 16'(push);
        writes_d    = writes_q + 16'(commit);
        addr_d      = addr_q + C_BUF_ADDR_WIDTH'(commit);
        count_d     = count_q;
        xaddr_d     = xaddr_q;
        xsize_d     = xsize_q;
        done_d      = 1'b0;
        state_d     = state_q;
        case (state_q)
            IDLE: if (ap_start) begin
                count_d  = ctrl_instruction[63:48];
                addr_d   = ctrl_instruction[32 +: C_BUF_ADDR_WIDTH];
                beats_d  = '0;
                writes_d = '0;
                xaddr_d  = ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(ctrl_instruction[79:64]);
                xsize_d  = C_XFER_SIZE_WIDTH'(ctrl_instruction[95:80]);
                state_d  = ctrl_instruction[63:48] == '0 ? DONE : ISSUE;
            end
            ISSUE:   state_d = STREAM;
            STREAM:  state_d = beats_d == count_q ? DRAIN : STREAM;
            DRAIN:   state_d = fcnt_q == '0 && writes_q == count_q ? DONE : DRAIN;
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            count_q     <= '0;
            beats_q     <= '0;
            writes_q    <= '0;
            addr_q      <= '0;
            xaddr_q     <= '0;
            xsize_q     <= '0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            beats_q     <= beats_d;
            writes_q    <= writes_d;
            addr_q      <= addr_d;
            xaddr_q     <= xaddr_d;
            xsize_q     <= xsize_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            assert (fcnt_q != (PW+1)'(C_FIFO_DEPTH)) else $error("push into full FIFO");
            mem_q[wr_ptr_q] <= data_tdata;
        end
    end

    assign ap_done                 = done_q;
    assign read_start              = state_q == ISSUE;
    assign read_xfer_addr          = xaddr_q;
    assign read_xfer_size_in_bytes = xsize_q;
    assign data_tready             = tready;
    assign load_write_buffer_valid = out_valid_q;
    assign load_write_buffer_addr  = addr_q;
    assign load_write_buffer_data  = out_data_q;
endmodule

// File: tb/tb_gnn_0_example_load.sv
// tb_gnn_0_example_load: directed load transfers checked against a queue-based scoreboard
// plus literal address/latency pins for the called-out corner cases.
module tb_gnn_0_example_load;
    logic         aclk = 1'b0, aresetn = 1'b0, ap_start = 1'b0, ap_done;
    logic [63:0]  ctrl_addr_offset = '0;
    logic [95:0]  ctrl_instruction = '0;
    logic         read_start;
    logic [63:0]  read_xfer_addr;
    logic [31:0]  read_xfer_size_in_bytes;
    logic         data_tvalid = 1'b0, data_tready;
    logic [511:0] data_tdata;
    logic         load_write_buffer_valid, load_write_buffer_ready = 1'b1;
    logic [10:0]  load_write_buffer_addr;
    logic [511:0] load_write_buffer_data;

    always #5 aclk = ~aclk;

    gnn_0_example_load dut (
        .aclk(aclk), .aresetn(aresetn), .ap_start(ap_start), .ap_done(ap_done),
        .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
        .read_start(read_start), .read_xfer_addr(read_xfer_addr),
        .read_xfer_size_in_bytes(read_xfer_size_in_bytes),
        .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
        .load_write_buffer_valid(load_write_buffer_valid),
        .load_write_buffer_ready(load_write_buffer_ready),
        .load_write_buffer_addr(load_write_buffer_addr),
        .load_write_buffer_data(load_write_buffer_data)
    );

    // beat source: every accepted beat advances a distinctive pattern
    logic [15:0] bi = 16'h0;
    assign data_tdata = {16{bi, ~bi}};
    always @(posedge aclk) if (data_tvalid && data_tready) bi <= bi + 16'd1;

    int vectors = 0, miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // written by stimulus only, read by the compare process
    logic [10:0] lit_addrs[$];
    logic        lit_b2b = 1'b0, lit_x_en = 1'b0, to_flag = 1'b0;
    logic [63:0] lit_xaddr = '0;
    logic [31:0] lit_xsize = '0;

    // scoreboard state, owned by the compare process
    logic         busy = 1'b0, prev_stall = 1'b0, to_seen = 1'b0;
    logic         first_beat_seen = 1'b0, first_wr_seen = 1'b0;
    int           cyc = 0, rem = 0, cnt = 0, rs_cnt = 0, start_cyc = 0;
    int           first_beat_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0;
    logic [10:0]  next_addr = '0, held_a = '0;
    logic [511:0] held_d = '0;
    logic [63:0]  exp_xaddr = '0;
    logic [31:0]  exp_xsize = '0;
    logic [10:0]  exp_a[$], wlog[$];
    logic [511:0] exp_d[$];

    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) begin
            chk("rst_ap_done", {63'b0, ap_done}, 64'd0);
            chk("rst_read_start", {63'b0, read_start}, 64'd0);
            chk("rst_xfer_addr", read_xfer_addr, 64'd0);
            chk("rst_xfer_size", {32'b0, read_xfer_size_in_bytes}, 64'd0);
            chk("rst_tready", {63'b0, data_tready}, 64'd0);
            chk("rst_wr_valid", {63'b0, load_write_buffer_valid}, 64'd0);
            chk("rst_wr_addr", {53'b0, load_write_buffer_addr}, 64'd0);
            chkd("rst_wr_data", load_write_buffer_data, 512'd0);
            busy = 1'b0; rem = 0; prev_stall = 1'b0;
            exp_a.delete(); exp_d.delete();
        end else begin
            if (ap_start && !busy) begin
                busy = 1'b1;
                cnt = int'(ctrl_instruction[63:48]);
                rem = cnt;
                next_addr = ctrl_instruction[42:32];
                exp_xaddr = ctrl_addr_offset + {48'b0, ctrl_instruction[79:64]};
                exp_xsize = {16'b0, ctrl_instruction[95:80]};
                start_cyc = cyc; rs_cnt = 0;
                first_beat_seen = 1'b0; first_wr_seen = 1'b0;
                wlog.delete();
            end
            if (!(busy && rem > 0))
                chk("tready_not_owed", {63'b0, data_tready}, 64'd0);
            if (data_tvalid && data_tready && rem > 0) begin
                if (!first_beat_seen) begin first_beat_seen = 1'b1; first_beat_cyc = cyc; end
                exp_a.push_back(next_addr);
                exp_d.push_back(data_tdata);
                next_addr = next_addr + 11'd1;
                rem--;
            end
            if (prev_stall) begin
                chk("stall_valid_held", {63'b0, load_write_buffer_valid}, 64'd1);
                chk("stall_addr_held", {53'b0, load_write_buffer_addr}, {53'b0, held_a});
                chkd("stall_data_held", load_write_buffer_data, held_d);
            end
            if (load_write_buffer_valid && !first_wr_seen && first_beat_seen) begin
                first_wr_seen = 1'b1; first_wr_cyc = cyc;
                chk("first_write_latency", 64'(cyc - first_beat_cyc), 64'd2);
            end
            if (load_write_buffer_valid && load_write_buffer_ready) begin
                chk("write_expected", {63'b0, exp_a.size() != 0}, 64'd1);
                if (exp_a.size() != 0) begin
                    chk("write_addr", {53'b0, load_write_buffer_addr}, {53'b0, exp_a.pop_front()});
                    chkd("write_data", load_write_buffer_data, exp_d.pop_front());
                end
                wlog.push_back(load_write_buffer_addr);
                last_wr_cyc = cyc;
            end
            prev_stall = load_write_buffer_valid && !load_write_buffer_ready;
            held_a = load_write_buffer_addr;
            held_d = load_write_buffer_data;
            if (read_start) begin
                rs_cnt++;
                chk("read_start_owed", {63'b0, busy && cnt != 0 && rs_cnt == 1}, 64'd1);
                chk("read_xfer_addr", read_xfer_addr, exp_xaddr);
                chk("read_xfer_size", {32'b0, read_xfer_size_in_bytes}, {32'b0, exp_xsize});
                if (lit_x_en) begin
                    chk("pin_xfer_addr", read_xfer_addr, lit_xaddr);
                    chk("pin_xfer_size", {32'b0, read_xfer_size_in_bytes}, {32'b0, lit_xsize});
                end
            end
            if (!busy) chk("no_done_when_idle", {63'b0, ap_done}, 64'd0);
            else if (ap_done) begin
                chk("done_writes_pending", 64'(exp_a.size()), 64'd0);
                chk("done_beats_left", 64'(rem), 64'd0);
                chk("done_read_starts", 64'(rs_cnt), {63'b0, cnt != 0});
                if (cnt == 0) chk("zero_count_done_latency", 64'(cyc - start_cyc), 64'd2);
                if (lit_addrs.size() != 0) begin
                    chk("pin_write_count", 64'(wlog.size()), 64'(lit_addrs.size()));
                    for (int i = 0; i < lit_addrs.size() && i < wlog.size(); i++)
                        chk("pin_write_addr", {53'b0, wlog[i]}, {53'b0, lit_addrs[i]});
                end
                if (lit_b2b) chk("back_to_back_span", 64'(last_wr_cyc - first_wr_cyc), 64'(cnt - 1));
                busy = 1'b0;
            end
            if (to_flag && !to_seen) begin
                to_seen = 1'b1;
                chk("transfer_timeout", 64'd1, 64'd0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    function automatic logic [95:0] mk(input logic [15:0] sz, input logic [15:0] da,
                                        input logic [15:0] n, input logic [15:0] bs);
        return {sz, da, n, bs, 32'h0};
    endfunction

    task automatic start(input logic [63:0] off, input logic [95:0] inst);
        ctrl_addr_offset = off;
        ctrl_instruction = inst;
        ap_start = 1'b1;
        cycles(1);
        ap_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) return;
            cycles(1);
        end
        to_flag = 1'b1;
        cycles(2);
    endtask

    initial begin
        cycles(3);
        aresetn = 1'b1;
        cycles(2);
        data_tvalid = 1'b1;

        lit_addrs.delete();
        for (int i = 0; i < 8; i++) lit_addrs.push_back(11'h010 + 11'(i));
        lit_b2b = 1'b1;
        start(64'h0, mk(16'h0200, 16'h0100, 16'd8, 16'h0010));
        wait_idle();
        cycles(2);

        lit_b2b = 1'b0;
        lit_addrs.delete();
        start(64'h0, mk(16'h0200, 16'h0200, 16'd8, 16'h0020));
        cycles(4);
        load_write_buffer_ready = 1'b0;
        cycles(10);
        load_write_buffer_ready = 1'b1;
        wait_idle();
        cycles(2);

        lit_addrs.delete();
        lit_addrs.push_back(11'h7FE); lit_addrs.push_back(11'h7FF);
        lit_addrs.push_back(11'h000); lit_addrs.push_back(11'h001);
        start(64'h0, mk(16'h0100, 16'h0300, 16'd4, 16'h07FE));
        wait_idle();
        cycles(2);

        lit_addrs.delete();
        start(64'h0, mk(16'h0000, 16'h0000, 16'd0, 16'h0005));
        wait_idle();
        cycles(2);

        start(64'h0, mk(16'h0200, 16'h0400, 16'd8, 16'h0100));
        cycles(3);
        start(64'h0, mk(16'h0080, 16'h0500, 16'd3, 16'h0200));
        cycles(2);
        aresetn = 1'b0;
        cycles(1);
        aresetn = 1'b1;
        cycles(12);

        lit_x_en = 1'b1;
        lit_xaddr = 64'h1000_0040;
        lit_xsize = 32'h200;
        start(64'h1000_0000, mk(16'h0200, 16'h0040, 16'd2, 16'h0000));
        wait_idle();
        lit_x_en = 1'b0;
        cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
